pe_stream_feeder: RTL and testbench

Sequencer on the array side of a single PE's valid/ready ports, acting as transmitter for the PE's `filter`, `ifmap` and `ipsum` inputs and as receiver for its `opsum` output. It takes one job descriptor and one ordered upstream word stream. It asserts the PE's enable and configuration, then routes each upstream word to the correct PE input in the order the PE consumes them: filter block once, then per output column the ifmap words followed by the ipsum words. After each column it forwards the PE's opsum words to a downstream stream.

---
 rtl/pe_stream_feeder.sv | 239 +++++++++++++++++++++++
 tb/tb_pe_stream_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_feeder.sv
// rtl/pe_stream_feeder.sv - job sequencer routing one upstream word stream into a PE and forwarding its opsum words
module pe_stream_feeder #(
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 13,
    parameter int CNT_BITS    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] cfg_pe_config,
    input  logic [CNT_BITS-1:0]    cfg_filter_words,
    input  logic [CNT_BITS-1:0]    cfg_ifmap_first,
    input  logic [CNT_BITS-1:0]    cfg_ifmap_next,
    input  logic [CNT_BITS-1:0]    cfg_ipsum_words,
    input  logic [CNT_BITS-1:0]    cfg_opsum_words,
    input  logic [4:0]             cfg_last_col,
    output logic                   busy,
    output logic                   done,
    input  logic [DATA_BITS-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    output logic [DATA_BITS-1:0]   pe_filter,
    output logic [DATA_BITS-1:0]   pe_ifmap,
    output logic [DATA_BITS-1:0]   pe_ipsum,
    output logic                   pe_filter_valid,
    output logic                   pe_ifmap_valid,
    output logic                   pe_ipsum_valid,
    input  logic                   pe_filter_ready,
    input  logic                   pe_ifmap_ready,
    input  logic                   pe_ipsum_ready,
    input  logic [DATA_BITS-1:0]   pe_opsum,
    input  logic                   pe_opsum_valid,
    output logic                   pe_opsum_ready,
    output logic [DATA_BITS-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_FILTER,
        S_SEND_IFMAP,
        S_SEND_IPSUM,
        S_COLLECT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [CONFIG_SIZE-1:0] pe_config;
        logic [CNT_BITS-1:0]    filter_words;
        logic [CNT_BITS-1:0]    ifmap_first;
        logic [CNT_BITS-1:0]    ifmap_next;
        logic [CNT_BITS-1:0]    ipsum_words;
        logic [CNT_BITS-1:0]    opsum_words;
        logic [4:0]             last_col;
    } desc_t;

    typedef struct packed {
        state_e     st;
        logic [4:0] col;
    } entry_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_e              state_q, state_d;
    logic [4:0]          col_q, col_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    desc_t               desc_q, desc_d;
    logic                pe_en_q, pe_en_d;

    desc_t               cfg_desc;
    entry_t              start_entry, follow_entry;
    state_e              follow_st;
    logic [4:0]          follow_col;
    logic [CNT_BITS-1:0] cur_count;
    logic                xfer;
    logic                last_word;

    // Resolves the state actually occupied when entering `target`: zero-count
    // states fall through in the same cycle, including whole empty columns.
    function automatic entry_t enter_state(input state_e target, input logic [4:0] col,
                                           input desc_t d);
        entry_t r;
        r.st  = target;
        r.col = col;
        if (r.st == S_SEND_FILTER && d.filter_words == '0) r.st = S_SEND_IFMAP;
        if (r.st == S_SEND_IFMAP &&
            ((r.col == 5'd0) ? d.ifmap_first : d.ifmap_next) == '0) r.st = S_SEND_IPSUM;
        if (r.st == S_SEND_IPSUM && d.ipsum_words == '0) r.st = S_COLLECT;
        if (r.st == S_COLLECT && d.opsum_words == '0) begin
            if (r.col == d.last_col) begin
                r.st = S_DONE;
            end else begin
                r.col = r.col + 5'd1;
                if (d.ifmap_next != '0) begin
                    r.st = S_SEND_IFMAP;
                end else if (d.ipsum_words != '0) begin
                    r.st = S_SEND_IPSUM;
                end else begin
                    // every later column is empty as well
                    r.st  = S_DONE;
                    r.col = d.last_col;
                end
            end
        end
        return r;
    endfunction

    assign cfg_desc = '{
        pe_config:    cfg_pe_config,
        filter_words: cfg_filter_words,
        ifmap_first:  cfg_ifmap_first,
        ifmap_next:   cfg_ifmap_next,
        ipsum_words:  cfg_ipsum_words,
        opsum_words:  cfg_opsum_words,
        last_col:     cfg_last_col
    };

    always_comb begin
        in_ready        = 1'b0;
        pe_filter_valid = 1'b0;
        pe_ifmap_valid  = 1'b0;
        pe_ipsum_valid  = 1'b0;
        out_valid       = 1'b0;
        pe_opsum_ready  = 1'b0;
        cur_count       = '0;
        case (state_q)
            S_SEND_FILTER: begin
                pe_filter_valid = in_valid;
                in_ready        = pe_filter_ready;
                cur_count       = desc_q.filter_words;
            end
            S_SEND_IFMAP: begin
                pe_ifmap_valid = in_valid;
                in_ready       = pe_ifmap_ready;
                cur_count      = (col_q == 5'd0) ? desc_q.ifmap_first : desc_q.ifmap_next;
            end
            S_SEND_IPSUM: begin
                pe_ipsum_valid = in_valid;
                in_ready       = pe_ipsum_ready;
                cur_count      = desc_q.ipsum_words;
            end
            S_COLLECT: begin
                out_valid      = pe_opsum_valid;
                pe_opsum_ready = out_ready;
                cur_count      = desc_q.opsum_words;
            end
            default: ;
        endcase
    end

    assign xfer      = (in_valid & in_ready) | (pe_opsum_valid & pe_opsum_ready);
    assign last_word = (cnt_q + CNT_ONE) == cur_count;

    always_comb begin
        follow_st  = S_IDLE;
        follow_col = col_q;
        case (state_q)
            S_SEND_FILTER: follow_st = S_SEND_IFMAP;
            S_SEND_IFMAP:  follow_st = S_SEND_IPSUM;
            S_SEND_IPSUM:  follow_st = S_COLLECT;
            S_COLLECT: begin
                if (col_q == desc_q.last_col) begin
                    follow_st = S_DONE;
                end else begin
                    follow_st  = S_SEND_IFMAP;
                    follow_col = col_q + 5'd1;
                end
            end
            default: ;
        endcase
    end

    assign start_entry  = enter_state(S_SEND_FILTER, 5'd0, cfg_desc);
    assign follow_entry = enter_state(follow_st, follow_col, desc_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        desc_d  = desc_q;
        pe_en_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    desc_d  = cfg_desc;
                    pe_en_d = 1'b1;
                    state_d = start_entry.st;
                    col_d   = start_entry.col;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                col_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                if (xfer) begin
                    if (last_word) begin
                        state_d = follow_entry.st;
                        col_d   = follow_entry.col;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            cnt_q   <= '0;
            desc_q  <= '0;
            pe_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            desc_q  <= desc_d;
            pe_en_q <= pe_en_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pe_en     = pe_en_q;
    assign pe_config = desc_q.pe_config;
    assign pe_filter = in_data;
    assign pe_ifmap  = in_data;
    assign pe_ipsum  = in_data;
    assign out_data  = pe_opsum;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb/tb_pe_stream_feeder.sv - scoreboard bench for pe_stream_feeder with a queue-based job model
module tb_pe_stream_feeder;
    localparam int DW = 32;
    localparam int CW = 13;
    localparam int NW = 6;
    localparam int K_FILT = 0, K_IFMAP = 1, K_IPSUM = 2, K_OUT = 3, K_NONE = 4;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_pe_config = '0;
    logic [NW-1:0] cfg_filter_words = '0, cfg_ifmap_first = '0, cfg_ifmap_next = '0;
    logic [NW-1:0] cfg_ipsum_words = '0, cfg_opsum_words = '0;
    logic [4:0]    cfg_last_col = '0;
    logic          busy, done, in_ready, pe_en;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] pe_config;
    logic [DW-1:0] pe_filter, pe_ifmap, pe_ipsum, out_data;
    logic          pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid, pe_opsum_ready, out_valid;
    logic          pe_filter_ready = 1'b1, pe_ifmap_ready = 1'b1, pe_ipsum_ready = 1'b1;
    logic [DW-1:0] pe_opsum = '0;
    logic          pe_opsum_valid = 1'b0;
    logic          out_ready = 1'b1;

    ev_t           evq[$];
    logic [DW-1:0] up_words[$];
    logic [DW-1:0] op_words[$];
    int            n_vec = 0, n_err = 0, cyc = 0, done_due = -1, mode = 0, hold = 0;
    bit            in_reset = 1'b1, expect_en = 1'b0;
    logic [CW-1:0] exp_cfg = '0;

    always #5 clk = ~clk;

    pe_stream_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_pe_config(cfg_pe_config), .cfg_filter_words(cfg_filter_words),
        .cfg_ifmap_first(cfg_ifmap_first), .cfg_ifmap_next(cfg_ifmap_next),
        .cfg_ipsum_words(cfg_ipsum_words), .cfg_opsum_words(cfg_opsum_words),
        .cfg_last_col(cfg_last_col), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pe_en(pe_en), .pe_config(pe_config),
        .pe_filter(pe_filter), .pe_ifmap(pe_ifmap), .pe_ipsum(pe_ipsum),
        .pe_filter_valid(pe_filter_valid), .pe_ifmap_valid(pe_ifmap_valid),
        .pe_ipsum_valid(pe_ipsum_valid), .pe_filter_ready(pe_filter_ready),
        .pe_ifmap_ready(pe_ifmap_ready), .pe_ipsum_ready(pe_ipsum_ready),
        .pe_opsum(pe_opsum), .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream source, PE opsum source and ready patterns
    always @(posedge clk) begin
        #1;
        if (up_words.size() > 0) begin
            in_valid = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            in_data  = up_words[0];
        end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        if (op_words.size() > 0) begin
            pe_opsum_valid = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            pe_opsum       = op_words[0];
        end else begin
            pe_opsum_valid = 1'b0;
            pe_opsum       = $urandom;
        end
        pe_filter_ready = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
        pe_ipsum_ready  = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
        if (mode == 1)      pe_ifmap_ready = ~pe_ifmap_ready;
        else if (mode == 2) pe_ifmap_ready = ($urandom_range(3) != 0);
        else                pe_ifmap_ready = 1'b1;
        if (mode == 1) begin
            if (evq.size() > 0 && evq[0].kind == K_OUT) begin
                if (hold < 5) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                hold      = 0;
                out_ready = 1'b1;
            end
        end else begin
            out_ready = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // Scoreboard monitor: head of evq names the port the next word must use
    always @(negedge clk) begin
        int            hk, ak;
        logic [DW-1:0] hd, ad;
        logic          up_x, op_x, exp_rdy;
        cyc++;
        if (!in_reset) begin
            hk = (evq.size() > 0) ? evq[0].kind : K_NONE;
            hd = (evq.size() > 0) ? evq[0].data : '0;
            case (hk)
                K_FILT:  exp_rdy = pe_filter_ready;
                K_IFMAP: exp_rdy = pe_ifmap_ready;
                K_IPSUM: exp_rdy = pe_ipsum_ready;
                default: exp_rdy = 1'b0;
            endcase
            chk("filter_valid", 64'(pe_filter_valid), 64'(hk == K_FILT && in_valid));
            chk("ifmap_valid", 64'(pe_ifmap_valid), 64'(hk == K_IFMAP && in_valid));
            chk("ipsum_valid", 64'(pe_ipsum_valid), 64'(hk == K_IPSUM && in_valid));
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(hk == K_OUT && pe_opsum_valid));
            chk("opsum_ready", 64'(pe_opsum_ready), 64'(hk == K_OUT && out_ready));
            chk("done", 64'(done), 64'(cyc == done_due));
            chk("pe_data", 64'({pe_filter ^ in_data} | {pe_ifmap ^ in_data} | {pe_ipsum ^ in_data}), 64'(0));
            chk("out_data", 64'(out_data), 64'(pe_opsum));
            if (pe_en && !expect_en) chk("pe_en_extra", 64'(pe_en), 64'(0));
            if (busy) chk("pe_config_hold", 64'(pe_config), 64'(exp_cfg));
            up_x = in_valid && in_ready;
            op_x = pe_opsum_valid && pe_opsum_ready;
            if (up_x || op_x) begin
                if (evq.size() == 0) begin
                    chk("unexpected_xfer", 64'(up_x || op_x), 64'(0));
                end else begin
                    if (op_x)                 begin ak = K_OUT;   ad = out_data;  end
                    else if (pe_filter_valid) begin ak = K_FILT;  ad = pe_filter; end
                    else if (pe_ifmap_valid)  begin ak = K_IFMAP; ad = pe_ifmap;  end
                    else if (pe_ipsum_valid)  begin ak = K_IPSUM; ad = pe_ipsum;  end
                    else                      begin ak = K_NONE;  ad = '0;        end
                    chk("xfer_port", 64'(ak), 64'(hk));
                    chk("xfer_data", 64'(ad), 64'(hd));
                    void'(evq.pop_front());
                    if (evq.size() == 0) done_due = cyc + 1;
                end
                if (up_x && up_words.size() > 0) void'(up_words.pop_front());
                if (op_x && op_words.size() > 0) void'(op_words.pop_front());
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        in_reset = 1'b1;
        start = 1'b0;
        evq.delete();
        up_words.delete();
        op_words.delete();
        done_due = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic run_job(input logic [CW-1:0] c, input int f, input int i0, input int i1,
                           input int ip, input int op, input int lc, input int md,
                           input bit mid_start, input bit rst_ipsum);
        ev_t pend[$];
        ev_t e;
        int  n;
        bit  finished;
        for (int k = 0; k < f; k++) begin
            e.kind = K_FILT; e.data = $urandom; pend.push_back(e); up_words.push_back(e.data);
        end
        for (int col = 0; col <= lc; col++) begin
            n = (col == 0) ? i0 : i1;
            for (int k = 0; k < n; k++) begin
                e.kind = K_IFMAP; e.data = $urandom; pend.push_back(e); up_words.push_back(e.data);
            end
            for (int k = 0; k < ip; k++) begin
                e.kind = K_IPSUM; e.data = $urandom; pend.push_back(e); up_words.push_back(e.data);
            end
            for (int k = 0; k < op; k++) begin
                e.kind = K_OUT; e.data = $urandom; pend.push_back(e); op_words.push_back(e.data);
            end
        end
        mode = md;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_pe_config = c;
        cfg_filter_words = NW'(f); cfg_ifmap_first = NW'(i0); cfg_ifmap_next = NW'(i1);
        cfg_ipsum_words = NW'(ip); cfg_opsum_words = NW'(op); cfg_last_col = 5'(lc);
        @(posedge clk);
        #1;
        start = 1'b0;
        evq = pend;
        exp_cfg = c;
        expect_en = 1'b1;
        cfg_pe_config = CW'($urandom);
        cfg_filter_words = NW'($urandom); cfg_ifmap_first = NW'($urandom); cfg_ifmap_next = NW'($urandom);
        cfg_ipsum_words = NW'($urandom); cfg_opsum_words = NW'($urandom); cfg_last_col = 5'($urandom);
        @(negedge clk);
        chk("start_pe_en", 64'(pe_en), 64'(1));
        chk("start_pe_config", 64'(pe_config), 64'(c));
        chk("start_busy", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        expect_en = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                finished = 1'b1;
            end else if (mid_start && k == 5) begin
                start = 1'b1;
                cfg_pe_config = ~c;
            end else if (rst_ipsum && evq.size() > 0 && evq[0].kind == K_IPSUM) begin
                reset_dut();
                @(negedge clk);
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_handshakes", 64'({in_ready, pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid,
                                           out_valid, pe_opsum_ready}), 64'(0));
                return;
            end
        end
        if (!finished) begin
            chk("job_timeout", 64'(done), 64'(1));
            reset_dut();
        end else begin
            @(negedge clk);
            chk("end_busy", 64'(busy), 64'(0));
            chk("end_queue_empty", 64'(evq.size()), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_dut();
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_pe_en", 64'(pe_en), 64'(0));
        chk("reset_pe_config", 64'(pe_config), 64'(0));
        chk("reset_handshakes", 64'({in_ready, pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid,
                                     out_valid, pe_opsum_ready}), 64'(0));
        run_job(13'h0A5, 4, 3, 1, 4, 4, 2, 0, 1'b0, 1'b0);
        run_job(13'h15A, 4, 3, 1, 4, 4, 2, 1, 1'b0, 1'b0);
        run_job(13'h0F0, 2, 3, 2, 0, 2, 0, 0, 1'b0, 1'b0);
        run_job(13'h1B3, 4, 3, 1, 4, 4, 2, 2, 1'b1, 1'b0);
        run_job(13'h077, 4, 3, 1, 4, 4, 2, 0, 1'b0, 1'b1);
        run_job(13'h1C1, 4, 3, 1, 4, 4, 2, 0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            run_job(CW'($urandom), $urandom_range(4), $urandom_range(4), $urandom_range(3),
                    $urandom_range(3), $urandom_range(3, 1), $urandom_range(3), 2, 1'b0, 1'b0);
        end
        mode = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
